// File: rtl/demultiplexer_n_1to2_stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | demultiplexer_n_1to2_stream_pkg                                          |
// | Lane encodings shared by the 1-to-2 stream demultiplexer.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package demultiplexer_n_1to2_stream_pkg;

   localparam logic LANE0 = 1'b0;
   localparam logic LANE1 = 1'b1;

endpackage : demultiplexer_n_1to2_stream_pkg
`default_nettype wire

// File: rtl/demultiplexer_n_1to2_stream_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | demux_lane_reg                                                           |
// | One-entry output holding register with delivered-word counter.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module demux_lane_reg #(
   parameter int N     = 10,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [N-1:0]     data_in,
   input  logic             out_ready,
   output logic [N-1:0]     out_data,
   output logic             out_valid,
   output logic [CNT_W-1:0] count
);

   logic [N-1:0]     r_data;
   logic             r_valid;
   logic [CNT_W-1:0] r_count;
   logic             w_drain;

   assign w_drain = r_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_count <= '0;
      end else begin
         // A load wins over a drain: the lane stays full with the new word.
         if (load) begin
            r_data  <= data_in;
            r_valid <= 1'b1;
         end else if (w_drain) begin
            r_valid <= 1'b0;
         end
         if (w_drain) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign out_data  = r_data;
   assign out_valid = r_valid;
   assign count     = r_count;

endmodule : demux_lane_reg
`default_nettype wire

// File: rtl/demultiplexer_n_1to2_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | demultiplexer_n_1to2_stream                                              |
// | Registered 1-to-2 valid/ready stream demultiplexer with lane counters.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module demultiplexer_n_1to2_stream
   import demultiplexer_n_1to2_stream_pkg::*;
#(
   parameter int N     = 10,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     channel_in,
   input  logic             in_valid,
   input  logic             select,
   output logic             in_ready,
   output logic [N-1:0]     out0,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [N-1:0]     out1,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [CNT_W-1:0] count0,
   output logic [CNT_W-1:0] count1
);

   logic w_lane0_free;
   logic w_lane1_free;
   logic w_accept;
   logic w_load0;
   logic w_load1;

   // A lane can take a word if empty or if it is being drained this cycle.
   assign w_lane0_free = ~out0_valid | out0_ready;
   assign w_lane1_free = ~out1_valid | out1_ready;

   assign in_ready = ~rst & ((select == LANE1) ? w_lane1_free : w_lane0_free);
   assign w_accept = in_valid & in_ready;
   assign w_load0  = w_accept & (select == LANE0);
   assign w_load1  = w_accept & (select == LANE1);

   demux_lane_reg #(
      .N     (N),
      .CNT_W (CNT_W)
   ) u_lane0 (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load0),
      .data_in   (channel_in),
      .out_ready (out0_ready),
      .out_data  (out0),
      .out_valid (out0_valid),
      .count     (count0)
   );

   demux_lane_reg #(
      .N     (N),
      .CNT_W (CNT_W)
   ) u_lane1 (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load1),
      .data_in   (channel_in),
      .out_ready (out1_ready),
      .out_data  (out1),
      .out_valid (out1_valid),
      .count     (count1)
   );

endmodule : demultiplexer_n_1to2_stream
`default_nettype wire
